vproc_mem_resp: RTL and testbench

VPROC_MEM_RESP -- requirements
Module: vproc_mem_resp

---
 rtl/vproc_mem_resp.sv | 95 +++++++++
 tb/tb_vproc_mem_resp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vproc_mem_resp.sv
// Word-addressed memory responder with a fixed-latency, in-order response pipeline.
// Grants are throttled by backpressure and by a cap on outstanding counted responses.
module vproc_mem_resp #(
    parameter int unsigned ADDR_BIT_W = 16,
    parameter int unsigned MEM_BYTE_W = 4,
    parameter int unsigned MEM_BYTES  = 65536,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned WRITE_RESP = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_i,
    input  logic                    mem_req_i,
    input  logic [ADDR_BIT_W-1:0]   mem_addr_i,
    input  logic                    mem_we_i,
    input  logic [MEM_BYTE_W*8-1:0] mem_wdata_i,
    output logic                    mem_gnt_o,
    output logic                    mem_rvalid_o,
    output logic [MEM_BYTE_W*8-1:0] mem_rdata_o,
    output logic                    mem_err_o
);

    localparam int unsigned WORD_W = MEM_BYTE_W * 8;
    localparam int unsigned OFF_W  = $clog2(MEM_BYTE_W);
    localparam int unsigned WORDS  = MEM_BYTES / MEM_BYTE_W;
    localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTST) + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    logic [WORD_W-1:0] mem_q [WORDS];

    logic [63:0]       addr_ext;
    logic              in_range;
    logic [IDX_W-1:0]  word_idx;
    logic              resp_retire;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic              push_err;
    logic [CNT_W-1:0]  outst_cnt_q;

    logic [LATENCY-1:0]             vld_q;
    logic [LATENCY-1:0][WORD_W-1:0] data_q;
    logic [LATENCY-1:0]             err_q;

    // Widen the address so the range test also works when MEM_BYTES fills the address space.
    assign addr_ext = 64'(mem_addr_i);
    assign in_range = addr_ext < 64'(MEM_BYTES);
    assign word_idx = addr_ext[OFF_W +: IDX_W];

    assign resp_retire = vld_q[LATENCY-1];
    assign mem_gnt_o   = mem_req_i & ~stall_i & ((outst_cnt_q < MAX_CNT) | resp_retire);
    assign push        = mem_gnt_o & (~mem_we_i | (WRITE_RESP != 0));
    assign push_data   = (mem_we_i | ~in_range) ? '0 : mem_q[word_idx];
    assign push_err    = ~in_range;

    // Storage is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (mem_gnt_o && mem_we_i && in_range) begin
            mem_q[word_idx] <= mem_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q       <= '0;
            outst_cnt_q <= '0;
        end else begin
            vld_q[0] <= push;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            case ({push, resp_retire})
                2'b10:   outst_cnt_q <= outst_cnt_q + CNT_W'(1);
                2'b01:   outst_cnt_q <= outst_cnt_q - CNT_W'(1);
                default: outst_cnt_q <= outst_cnt_q;
            endcase
        end
    end

    // Payload shifts unconditionally; the valid bits decide what is visible.
    always_ff @(posedge clk_i) begin
        data_q[0] <= push_data;
        err_q[0]  <= push_err;
        for (int i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
            err_q[i]  <= err_q[i-1];
        end
    end

    assign mem_rvalid_o = vld_q[LATENCY-1];
    assign mem_rdata_o  = vld_q[LATENCY-1] ? data_q[LATENCY-1] : '0;
    assign mem_err_o    = vld_q[LATENCY-1] & err_q[LATENCY-1];

endmodule

// File: tb/tb_vproc_mem_resp.sv
// Bench for vproc_mem_resp: queue-based response model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vproc_mem_resp;

    localparam int AW  = 17;
    localparam int LAT = 4;
    localparam int MO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        mem_req_i;
    logic [16:0] mem_addr_i;
    logic        mem_we_i;
    logic [31:0] mem_wdata_i;
    logic        mem_gnt_o;
    logic        mem_rvalid_o;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        bit          known;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mem_model [int];

    vproc_mem_resp #(
        .ADDR_BIT_W(AW),
        .MEM_BYTE_W(4),
        .MEM_BYTES (65536),
        .LATENCY   (LAT),
        .MAX_OUTST (MO),
        .WRITE_RESP(0)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .stall_i     (stall_i),
        .mem_req_i   (mem_req_i),
        .mem_addr_i  (mem_addr_i),
        .mem_we_i    (mem_we_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_gnt_o   (mem_gnt_o),
        .mem_rvalid_o(mem_rvalid_o),
        .mem_rdata_o (mem_rdata_o),
        .mem_err_o   (mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: each granted read becomes an entry due LAT cycles later; a cap of MO
    // entries limits grants unless the oldest entry leaves in the same cycle.
    resp_t r;
    bit    retire;
    bit    exp_gnt;
    bit    inr;
    int    w;
    always @(negedge clk_i) begin
        cyc++;
        if (!rst_ni) begin
            q.delete();
            chk("rst_gnt", 32'(mem_gnt_o), 32'(mem_req_i & ~stall_i));
            chk("rst_rvalid", 32'(mem_rvalid_o), 0);
            chk("rst_rdata", mem_rdata_o, 0);
            chk("rst_err", 32'(mem_err_o), 0);
        end else begin
            retire  = (q.size() != 0) && (q[0].due == cyc);
            exp_gnt = mem_req_i && !stall_i && (q.size() < MO || retire);
            chk("gnt", 32'(mem_gnt_o), 32'(exp_gnt));
            chk("rvalid", 32'(mem_rvalid_o), 32'(retire));
            if (retire) begin
                if (q[0].known) chk("rdata", mem_rdata_o, q[0].data);
                chk("err", 32'(mem_err_o), 32'(q[0].err));
                void'(q.pop_front());
            end else begin
                chk("idle_rdata", mem_rdata_o, 0);
                chk("idle_err", 32'(mem_err_o), 0);
            end
            if (exp_gnt) begin
                inr = mem_addr_i < 17'h10000;
                w   = int'(mem_addr_i[15:2]);
                if (!mem_we_i) begin
                    r.due   = cyc + LAT;
                    r.err   = !inr;
                    r.known = !inr || mem_model.exists(w);
                    r.data  = (inr && r.known) ? mem_model[w] : 32'h0;
                    q.push_back(r);
                end else if (inr) begin
                    mem_model[w] = mem_wdata_i;
                end
            end
        end
    end

    // All tasks start and end 1ns after a rising edge.
    task automatic req_once(input logic [16:0] a, input logic we, input logic [31:0] wd, output int gc);
        bit got = 0;
        gc = -1;
        mem_req_i = 1'b1; mem_addr_i = a; mem_we_i = we; mem_wdata_i = wd;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i); #1;
            if (mem_gnt_o) begin got = 1; gc = cyc; end
            @(posedge clk_i); #1;
        end
        mem_req_i = 1'b0;
        if (!got) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_resp(output logic [31:0] d, output logic e, output int rc);
        bit got = 0;
        rc = -1; d = '0; e = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk_i); #1;
            if (mem_rvalid_o) begin got = 1; rc = cyc; d = mem_rdata_o; e = mem_err_o; end
            @(posedge clk_i); #1;
        end
        if (!got) chk("rvalid_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    logic [16:0] pool [10] = '{17'h00000, 17'h00100, 17'h00200, 17'h00204, 17'h00208,
                               17'h0020C, 17'h00300, 17'h0FFFC, 17'h10000, 17'h1FFFC};

    initial begin
        int          gw, gr, g0, g1, rc, n, nr, cnt;
        logic [31:0] d, sd;
        logic        e, g;
        logic [7:0]  pat;
        logic [31:0] rd [4];

        rst_ni = 1'b0; stall_i = 1'b0; mem_req_i = 1'b0;
        mem_addr_i = '0; mem_we_i = 1'b0; mem_wdata_i = '0;
        idle(2);
        // A read requested during reset is granted but must not produce a response.
        mem_req_i = 1'b1;
        @(negedge clk_i); #1;
        chk("rst_lit_gnt", 32'(mem_gnt_o), 1);
        chk("rst_lit_rvalid", 32'(mem_rvalid_o), 0);
        @(posedge clk_i); #1;
        mem_req_i = 1'b0;
        idle(1);
        rst_ni = 1'b1;

        // Write then immediately read the same word.
        req_once(17'h00100, 1'b1, 32'hDEADBEEF, gw);
        req_once(17'h00100, 1'b0, 32'h0, gr);
        chk("wr_rd_gnt_gap", 32'(gr - gw), 1);
        wait_resp(d, e, rc);
        chk("rd_latency", 32'(rc - gr), LAT);
        chk("rd_data_lit", d, 32'hDEADBEEF);
        chk("rd_err_lit", 32'(e), 0);

        // Four words, then continuous reads throttled by the outstanding cap.
        for (int i = 0; i < 4; i++) req_once(17'h00200 + 17'(4 * i), 1'b1, 32'(i + 1), gw);
        idle(2);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 17'h00200;
        n = 0; nr = 0; pat = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i); #1;
            if (k < 8) pat = {pat[6:0], mem_gnt_o};
            if (mem_gnt_o) n++;
            if (mem_rvalid_o && nr < 4) begin rd[nr] = mem_rdata_o; nr++; end
            @(posedge clk_i); #1;
            mem_addr_i = 17'h00200 + 17'(4 * (n % 4));
        end
        mem_req_i = 1'b0;
        chk("gnt_pattern", 32'(pat), 32'hCC);
        chk("b2b_resp_count", 32'(nr), 4);
        for (int i = 0; i < 4; i++) chk("b2b_rdata_lit", rd[i], 32'(i + 1));
        idle(8);

        // Out-of-range read and write.
        req_once(17'h00000, 1'b1, 32'h11112222, gw);
        req_once(17'h10000, 1'b0, 32'h0, gr);
        wait_resp(d, e, rc);
        chk("oor_rdata", d, 0);
        chk("oor_err", 32'(e), 1);
        req_once(17'h10000, 1'b1, 32'hFFFFFFFF, gw);
        req_once(17'h00000, 1'b0, 32'h0, gr);
        wait_resp(d, e, rc);
        chk("oor_wr_ignored", d, 32'h11112222);
        chk("oor_wr_err", 32'(e), 0);

        // Stall for three cycles while an earlier read is still in flight.
        req_once(17'h00300, 1'b1, 32'h0000A5A5, gw);
        req_once(17'h00300, 1'b0, 32'h0, g0);
        idle(1);
        stall_i = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 17'h00100;
        cnt = 0; sd = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); #1;
            chk("stall_gnt", 32'(mem_gnt_o), 0);
            if (mem_rvalid_o) begin cnt++; sd = mem_rdata_o; end
            @(posedge clk_i); #1;
        end
        chk("stall_inflight_cnt", 32'(cnt), 1);
        chk("stall_inflight_data", sd, 32'h0000A5A5);
        stall_i = 1'b0;
        @(negedge clk_i); #1;
        chk("stall_release_gnt", 32'(mem_gnt_o), 1);
        g1 = cyc;
        @(posedge clk_i); #1;
        mem_req_i = 1'b0;
        cnt = 0; rc = -1; sd = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i); #1;
            if (mem_rvalid_o) begin cnt++; if (rc < 0) begin rc = cyc; sd = mem_rdata_o; end end
            @(posedge clk_i); #1;
        end
        chk("stall_single_resp", 32'(cnt), 1);
        chk("stall_resp_latency", 32'(rc - g1), LAT);
        chk("stall_resp_data", sd, 32'hDEADBEEF);

        // Reset with two reads in flight.
        req_once(17'h00200, 1'b0, 32'h0, gr);
        req_once(17'h00204, 1'b0, 32'h0, gr);
        rst_ni = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i); #1;
            if (mem_rvalid_o) cnt++;
            @(posedge clk_i); #1;
            if (k == 1) rst_ni = 1'b1;
        end
        chk("rst_drop_count", 32'(cnt), 0);
        req_once(17'h00204, 1'b0, 32'h0, gr);
        wait_resp(d, e, rc);
        chk("rst_retained_data", d, 32'h2);

        // Randomized traffic; a request is held until granted.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk_i); #1;
            g = mem_gnt_o;
            @(posedge clk_i); #1;
            if (g || !mem_req_i) begin
                mem_req_i   = $urandom_range(0, 3) != 0;
                mem_we_i    = $urandom_range(0, 1) != 0;
                mem_addr_i  = pool[$urandom_range(0, 9)] | 17'($urandom_range(0, 3));
                mem_wdata_i = $urandom;
            end
            stall_i = $urandom_range(0, 3) == 0;
        end
        mem_req_i = 1'b0; stall_i = 1'b0;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
